// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding, default width and
// counter sizing.
package div_pkg;

   localparam int unsigned DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StFix  = 2'd2,
      StDone = 2'd3
   } div_state_e;

   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

   localparam int unsigned DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_passo.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and
// trial-subtract the divisor.
module div_passo #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] r_i,
   input  logic             q_msb_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] r_o,
   output logic             q_bit_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // r_i < divisor_i always holds, so the difference fits WIDTH+1 bits with diff[WIDTH] as sign.
   always_comb begin
      shifted = {r_i, q_msb_i};
      diff    = shifted - {1'b0, divisor_i};
      q_bit_o = ~diff[WIDTH];
      r_o     = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/divisor_seq.sv
// Sequential restoring divider, one quotient bit per cycle. Define DIVISOR_SIGNED_EN to add the
// Sinal port and truncating signed division (one extra sign fix-up cycle).
module divisor_seq
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividendo,
   input  logic [WIDTH-1:0] Divisor,
`ifdef DIVISOR_SIGNED_EN
   input  logic             Sinal,
`endif
   output logic [WIDTH-1:0] Quociente,
   output logic [WIDTH-1:0] Resto,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero
);

   localparam int unsigned CntW = cnt_width(WIDTH);

   div_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic            zero_q, zero_d;
   logic            dz_q, dz_d;
   logic            sgn_q, sgn_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;

   logic             sinal_w;
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] step_r;
   logic             step_bit;

`ifdef DIVISOR_SIGNED_EN
   assign sinal_w = Sinal;
`else
   assign sinal_w = 1'b0;
`endif

   div_passo #(
      .WIDTH (WIDTH)
   ) u_passo (
      .r_i       (r_q),
      .q_msb_i   (q_q[WIDTH-1]),
      .divisor_i (dvs_q),
      .r_o       (step_r),
      .q_bit_o   (step_bit)
   );

   always_comb begin
      a_neg = sinal_w & Dividendo[WIDTH-1];
      b_neg = sinal_w & Divisor[WIDTH-1];
      a_mag = a_neg ? -Dividendo : Dividendo;
      b_mag = b_neg ? -Divisor : Divisor;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (Start) state_d = StCalc;
         StCalc: begin
            if (zero_q || cnt_q == CntW'(1)) begin
               state_d = (sgn_q && !zero_q) ? StFix : StDone;
            end
         end
         StFix:  state_d = StDone;
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      Busy      = (state_q == StCalc) || (state_q == StFix);
      Done      = (state_q == StDone);
      Quociente = q_q;
      Resto     = r_q;
      DivZero   = dz_q;
   end

   always_comb begin
      cnt_d  = cnt_q;
      r_d    = r_q;
      q_d    = q_q;
      dvs_d  = dvs_q;
      zero_d = zero_q;
      dz_d   = dz_q;
      sgn_d  = sgn_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      unique case (state_q)
         StIdle: begin
            if (Start) begin
               zero_d = (Divisor == '0);
               // Divide-by-zero keeps the raw dividend so it can be returned as the remainder.
               q_d    = (Divisor == '0) ? Dividendo : a_mag;
               r_d    = '0;
               dvs_d  = b_mag;
               cnt_d  = CntW'(WIDTH);
               dz_d   = 1'b0;
               sgn_d  = sinal_w;
               qneg_d = a_neg ^ b_neg;
               rneg_d = a_neg;
            end
         end
         StCalc: begin
            if (zero_q) begin
               q_d   = '1;
               r_d   = q_q;
               cnt_d = '0;
               dz_d  = 1'b1;
            end else begin
               r_d   = step_r;
               q_d   = {q_q[WIDTH-2:0], step_bit};
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StFix: begin
            if (qneg_q) q_d = -q_q;
            if (rneg_q) r_d = -r_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q  <= '0;
         r_q    <= '0;
         q_q    <= '0;
         dvs_q  <= '0;
         zero_q <= 1'b0;
         dz_q   <= 1'b0;
         sgn_q  <= 1'b0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         r_q    <= r_d;
         q_q    <= q_d;
         dvs_q  <= dvs_d;
         zero_q <= zero_d;
         dz_q   <= dz_d;
         sgn_q  <= sgn_d;
         qneg_q <= qneg_d;
         rneg_q <= rneg_d;
      end
   end

endmodule

// File: tb/tb_divisor_seq.sv
// Self-checking bench for divisor_seq: directed and random divisions compared against plain
// arithmetic, plus reset, latency and handshake checks.
module tb_divisor_seq;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividendo;
  logic [W-1:0] divisor;
  logic         sinal;
  logic [W-1:0] quociente;
  logic [W-1:0] resto;
  logic         busy;
  logic         done;
  logic         div_zero;

  int n_chk  = 0;
  int n_fail = 0;

  divisor_seq #(
    .WIDTH (W)
  ) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .Start     (start),
    .Dividendo (dividendo),
    .Divisor   (divisor),
`ifdef DIVISOR_SIGNED_EN
    .Sinal     (sinal),
`endif
    .Quociente (quociente),
    .Resto     (resto),
    .Busy      (busy),
    .Done      (done),
    .DivZero   (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the operands, signed only when the build supports it.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                       output int lat);
    logic use_sg;
`ifdef DIVISOR_SIGNED_EN
    use_sg = sg;
`else
    use_sg = 1'b0;
`endif
    if (b == '0) begin
      q = '1; r = a; dz = 1'b1; lat = 1;
    end else if (use_sg) begin
      if (a == MIN && b == '1) begin
        q = MIN; r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
      dz = 1'b0; lat = W + 1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0; lat = W;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                        input bit glitch, input string tag);
    logic [W-1:0] eq, er;
    logic         edz;
    int           lat;
    int           n;
    model(a, b, sg, eq, er, edz, lat);
    dividendo = a;
    divisor   = b;
    sinal     = sg;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    dividendo = $urandom;
    divisor   = $urandom;
    sinal     = ~sg;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $error("FAIL %s_busy: observed %0h expected 1", tag, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (glitch && n == 10) start = 1'b1;
      if (glitch && n == 11) start = 1'b0;
      tick();
      n++;
    end
    n_chk++;
    if (n !== lat) begin
      n_fail++;
      $error("FAIL %s_lat: observed %0d expected %0d", tag, n, lat);
    end
    n_chk++;
    if (quociente !== eq) begin
      n_fail++;
      $error("FAIL %s_q: observed %0h expected %0h", tag, quociente, eq);
    end
    n_chk++;
    if (resto !== er) begin
      n_fail++;
      $error("FAIL %s_r: observed %0h expected %0h", tag, resto, er);
    end
    n_chk++;
    if (div_zero !== edz) begin
      n_fail++;
      $error("FAIL %s_dz: observed %0h expected %0h", tag, div_zero, edz);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $error("FAIL %s_busy_done: observed %0h expected 0", tag, busy);
    end
    tick();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $error("FAIL %s_pulse: observed %0h expected 0", tag, done);
    end
    n_chk++;
    if (quociente !== eq) begin
      n_fail++;
      $error("FAIL %s_hold_q: observed %0h expected %0h", tag, quociente, eq);
    end
    n_chk++;
    if (div_zero !== edz) begin
      n_fail++;
      $error("FAIL %s_hold_dz: observed %0h expected %0h", tag, div_zero, edz);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, eq, er;
    logic         edz, rs;
    int           lat;
    int           n;

    rst_n = 1'b0; start = 1'b0; dividendo = '0; divisor = '0; sinal = 1'b0;
    #12;
    n_chk++;
    if (quociente !== {W{1'b0}}) begin
      n_fail++;
      $error("FAIL rst_q: observed %0h expected 0", quociente);
    end
    n_chk++;
    if (resto !== {W{1'b0}}) begin
      n_fail++;
      $error("FAIL rst_r: observed %0h expected 0", resto);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $error("FAIL rst_busy: observed %0h expected 0", busy);
    end
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $error("FAIL rst_done: observed %0h expected 0", done);
    end
    n_chk++;
    if (div_zero !== 1'b0) begin
      n_fail++;
      $error("FAIL rst_dz: observed %0h expected 0", div_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $error("FAIL idle_busy: observed %0h expected 0", busy);
    end

    // Reset in the middle of a calculation aborts it.
    dividendo = 32'd200; divisor = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $error("FAIL mid_busy: observed %0h expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (quociente !== {W{1'b0}}) begin
      n_fail++;
      $error("FAIL abort_q: observed %0h expected 0", quociente);
    end
    n_chk++;
    if (resto !== {W{1'b0}}) begin
      n_fail++;
      $error("FAIL abort_r: observed %0h expected 0", resto);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $error("FAIL abort_busy: observed %0h expected 0", busy);
    end
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $error("FAIL abort_done: observed %0h expected 0", done);
    end
    repeat (3) tick();
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $error("FAIL abort_nodone: observed %0h expected 0", done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $error("FAIL rel_busy: observed %0h expected 0", busy);
    end
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $error("FAIL rel_done: observed %0h expected 0", done);
    end

    run_op(32'd200, 32'd7, 1'b0, 1'b0, "basic");
    run_op(32'd7, 32'd200, 1'b0, 1'b0, "small");
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "max_by1");
    run_op(32'd5, 32'd5, 1'b0, 1'b0, "equal");
    run_op(32'd123, 32'd0, 1'b0, 1'b0, "divzero");
    run_op(32'd1000, 32'd3, 1'b0, 1'b0, "dz_clear");
    run_op(32'hDEAD_BEEF, 32'd977, 1'b0, 1'b1, "glitch");

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom) : 32'($urandom_range(1, 5000));
      if (i == 7) rb = '0;
      run_op(ra, rb, 1'b0, 1'b0, "rand_u");
    end

    // Start held high: back-to-back operations.
    model(32'd999_999, 32'd13, 1'b0, eq, er, edz, lat);
    dividendo = 32'd999_999; divisor = 32'd13; sinal = 1'b0; start = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_chk++;
    if (quociente !== eq) begin
      n_fail++;
      $error("FAIL held_q1: observed %0h expected %0h", quociente, eq);
    end
    tick();
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    start = 1'b0;
    n_chk++;
    if (n !== W + 2) begin
      n_fail++;
      $error("FAIL held_period: observed %0d expected %0d", n, W + 2);
    end
    n_chk++;
    if (quociente !== eq) begin
      n_fail++;
      $error("FAIL held_q2: observed %0h expected %0h", quociente, eq);
    end
    n_chk++;
    if (resto !== er) begin
      n_fail++;
      $error("FAIL held_r2: observed %0h expected %0h", resto, er);
    end
    repeat (2) tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $error("FAIL held_idle: observed %0h expected 0", busy);
    end

`ifdef DIVISOR_SIGNED_EN
    run_op(-32'sd200, 32'd7, 1'b1, 1'b0, "s_negdvd");
    run_op(32'd200, -32'sd7, 1'b1, 1'b0, "s_negdvs");
    run_op(-32'sd200, -32'sd7, 1'b1, 1'b0, "s_bothneg");
    run_op(MIN, 32'hFFFF_FFFF, 1'b1, 1'b0, "s_min_m1");
    run_op(-32'sd50, 32'd0, 1'b1, 1'b0, "s_divzero");
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom) : 32'($urandom_range(1, 300)) ^ {W{ra[0]}};
      rs = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, 1'b0, "rand_s");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no completion, expected summary before time limit");
    $fatal(1, "timeout");
  end

endmodule
